load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Initiator side of the word-wide data-memory port (MemWrite/Address/WriteData/ReadData).
//  Accepts load/store requests from the MEM stage via valid/ready.
//  Performs byte/half/word accesses over the word-only memory port, using read-modify-write for sb/sh.
//  Returns sign/zero-extended load data, or an error flag, via a one-cycle response pulse.
// PARAMETERS
//  MEM_WORDS    64  words in the attached data memory; byte addresses >= 4*MEM_WORDS are out of range
//  CHECK_RANGE  1   1: out-of-range access -> error; 0: no range check, address used as-is
// PORTS
//  clk           in   1   clock; all state updates on rising edge
//  reset         in   1   asynchronous, active-high reset
//  req_valid     in   1   request present
//  req_ready     out  1   unit can accept; handshake = req_valid & req_ready at rising edge
//  req_write     in   1   1 store, 0 load
//  req_size      in   2   00 byte, 01 half, 10 word; 11 -> error
//  req_unsigned  in   1   loads only: 1 zero-extend, 0 sign-extend
//  req_addr      in   32  byte address
//  req_wdata     in   32  store data, right-justified (byte in [7:0], half in [15:0])
//  resp_valid    out  1   one-cycle completion pulse
//  resp_error    out  1   valid with resp_valid: misaligned, bad size or out of range
//  resp_rdata    out  32  load result, valid with resp_valid; 0 for stores and errors
//  MemWrite      out  1   memory write enable; memory commits on rising edge
//  Address       out  32  memory byte address, always {addr[31:2],2'b00}
//  WriteData     out  32  memory write word
//  ReadData      in   32  memory read word, combinational from Address
// BEHAVIOUR
//  Reset: state IDLE. req_ready=1. resp_valid=0, resp_error=0. resp_rdata=0.
//   MemWrite=0, Address=0, WriteData=0. Applies immediately, mid-operation included.
//  Request latch: all req_* fields are latched on handshake; inputs are don't-care afterwards.
//  Byte lanes are little-endian in the word: offset 0 -> [7:0], offset 3 -> [31:24].
//  FSM states: IDLE, LOAD, WRITE, RMW_RD, RMW_WR.
//   IDLE: req_ready=1, MemWrite=0. On handshake:
//    - error (size 11 | half with addr[0] | word with addr[1:0]!=0 | range fault):
//      resp_valid=1 and resp_error=1 next cycle; stay IDLE; no memory access.
//    - load -> LOAD.
//    - sw -> WRITE.
//    - sb/sh -> RMW_RD.
//   LOAD (1 cyc): drive Address. Extract lane from ReadData and extend it into resp_rdata.
//    resp_valid next cycle; go to IDLE.
//   WRITE (1 cyc): MemWrite=1, WriteData=req_wdata. resp_valid next cycle; go to IDLE.
//   RMW_RD (1 cyc): MemWrite=0. Capture ReadData into the merge register; go to RMW_WR.
//   RMW_WR (1 cyc): MemWrite=1. WriteData = captured word with the addressed lane(s) replaced by req_wdata.
//    resp_valid next cycle; go to IDLE.
//  Latency from handshake edge to resp_valid high: err 1; lw/lb/lh/sw 2; sb/sh 3 cycles.
//  Throughput: req_ready=1 in the cycle resp_valid is high, so back-to-back requests overlap the response.
//  MemWrite is asserted only in WRITE and RMW_WR, exactly one cycle per store; it is 0 in all other states.
//  Address holds its last value when IDLE. WriteData=0 whenever MemWrite=0.
//  resp_valid is a registered output and is never high for two consecutive cycles for one request.
//  Reset asserted during WRITE or RMW_WR: MemWrite drops immediately. No commit unless a rising edge
//   has already passed. No resp_valid. Request is lost.
// TESTING
//  1 Initial mem[2]=0x11223344. sw 0x8 data 0xDEADBEEF -> MemWrite=1 only in cycle 1, Address=0x8;
//    resp_valid cycle 2; mem[2]=0xDEADBEEF.
//  2 mem[2]=0x11228344. lb 0x9 -> resp_rdata 0xFFFFFF83. lbu 0x9 -> 0x00000083. lhu 0xA -> 0x00001122.
//  3 mem[2]=0x11223344. sh 0xA data 0x0000ABCD -> MemWrite low in RMW_RD, high in RMW_WR;
//    WriteData 0xABCD3344; resp_valid at cycle 3.
//  4 Errors: lw 0x6, sh 0x3, size 11, lw 0x100 (MEM_WORDS=64) -> resp_error=1 one cycle after handshake;
//    MemWrite never asserted; memory unchanged.
//  5 Reset pulse mid-cycle in RMW_WR of sb 0x8 -> MemWrite falls at once; mem[2] unchanged;
//    resp_valid=0; req_ready=1 after release.
//  6 req_valid held high with lw 0x8 then sw 0xC -> second handshake occurs in the resp_valid cycle of the first;
//    no idle gap; both responses correct.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: drives a word-wide data-memory port for byte/half/word accesses
// requested by the MEM stage. Sub-word stores are done as a read-modify-write.
module load_store_unit #(
  parameter int MEM_WORDS   = 64,
  parameter bit CHECK_RANGE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_error,
  output logic [31:0] resp_rdata,
  output logic        MemWrite,
  output logic [31:0] Address,
  output logic [31:0] WriteData,
  input  logic [31:0] ReadData
);

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, RMW_RD, RMW_WR} state_t;

  localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_WORDS);

  state_t      state, next_state;
  logic [1:0]  lat_size;
  logic        lat_unsigned;
  logic [1:0]  lat_offset;
  logic [31:0] lat_wdata;
  logic [31:0] merge_word;
  logic [31:0] addr_reg;

  logic        req_err;
  logic        misalign;
  logic        range_fault;
  logic [4:0]  lane_shift;
  logic [31:0] rd_shifted;
  logic [31:0] load_value;
  logic [31:0] lane_mask;
  logic [31:0] merged_word;
  logic        resp_valid_next;
  logic        resp_error_next;
  logic [31:0] resp_rdata_next;

  assign Address    = addr_reg;
  assign lane_shift = {lat_offset, 3'b000};

  always_comb begin
    range_fault = CHECK_RANGE && (req_addr >= ADDR_LIMIT);
    case (req_size)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = req_addr[0];
      2'b10:   misalign = |req_addr[1:0];
      default: misalign = 1'b1;
    endcase
    req_err = misalign | range_fault;
  end

  // Lane extraction for loads and lane insertion for the RMW store path.
  always_comb begin
    rd_shifted = ReadData >> lane_shift;
    case (lat_size)
      2'b00:   load_value = lat_unsigned ? {24'h0, rd_shifted[7:0]}
                                         : {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      2'b01:   load_value = lat_unsigned ? {16'h0, rd_shifted[15:0]}
                                         : {{16{rd_shifted[15]}}, rd_shifted[15:0]};
      default: load_value = rd_shifted;
    endcase
    lane_mask   = (lat_size == 2'b00) ? (32'h0000_00FF << lane_shift)
                                      : (32'h0000_FFFF << lane_shift);
    merged_word = (merge_word & ~lane_mask) | ((lat_wdata << lane_shift) & lane_mask);
  end

  always_comb begin
    next_state      = state;
    req_ready       = 1'b0;
    MemWrite        = 1'b0;
    WriteData       = 32'h0;
    resp_valid_next = 1'b0;
    resp_error_next = 1'b0;
    resp_rdata_next = 32'h0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err) begin
            resp_valid_next = 1'b1;
            resp_error_next = 1'b1;
          end else if (!req_write) begin
            next_state = LOAD;
          end else if (req_size == 2'b10) begin
            next_state = WRITE;
          end else begin
            next_state = RMW_RD;
          end
        end
      end
      LOAD: begin
        resp_valid_next = 1'b1;
        resp_rdata_next = load_value;
        next_state      = IDLE;
      end
      WRITE: begin
        MemWrite        = 1'b1;
        WriteData       = lat_wdata;
        resp_valid_next = 1'b1;
        next_state      = IDLE;
      end
      RMW_RD: begin
        next_state = RMW_WR;
      end
      RMW_WR: begin
        MemWrite        = 1'b1;
        WriteData       = merged_word;
        resp_valid_next = 1'b1;
        next_state      = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Rejected requests leave Address untouched since they never reach memory.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      resp_valid   <= 1'b0;
      resp_error   <= 1'b0;
      resp_rdata   <= 32'h0;
      addr_reg     <= 32'h0;
      lat_size     <= 2'b00;
      lat_unsigned <= 1'b0;
      lat_offset   <= 2'b00;
      lat_wdata    <= 32'h0;
      merge_word   <= 32'h0;
    end else begin
      state      <= next_state;
      resp_valid <= resp_valid_next;
      resp_error <= resp_error_next;
      resp_rdata <= resp_rdata_next;
      if (state == IDLE && req_valid && !req_err) begin
        addr_reg     <= {req_addr[31:2], 2'b00};
        lat_size     <= req_size;
        lat_unsigned <= req_unsigned;
        lat_offset   <= req_addr[1:0];
        lat_wdata    <= req_wdata;
      end
      if (state == RMW_RD) begin
        merge_word <= ReadData;
      end
    end
  end

endmodule
